// File: rtl/t07_regfile_wb_arbiter.sv
// t07_regfile_wb_arbiter
//   Shares the register-file write port between the ALU writeback (A) and
//   load-return writeback (B). The two requesters are arbitrated round-robin
//   over valid/ready handshakes. The winning write reaches the register file
//   one cycle after it is accepted. A pending-load scoreboard drives a hazard
//   flag, so decode can stall on a source register that is still waiting for
//   a load.
//
// Ports
//   clk, nrst                   clock, synchronous active-low reset
//   a_valid/a_reg/a_data        ALU writeback request
//   a_ready                     A accepted this cycle
//   b_valid/b_reg/b_data        load writeback request
//   b_ready                     B accepted this cycle
//   issue_valid/issue_reg       load issued; mark destination pending
//   rs1, rs2                    decode-stage source registers
//   hazard                      a non-zero source has a pending load
//   reg_write/write_reg/
//   write_data                  register-file write port
module t07_regfile_wb_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter bit B_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              hazard,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data
);

  localparam int NREG = 2 ** ADDR_W;

  // r_prio: 1 = B wins under contention, 0 = A wins
  logic              r_prio;
  logic              r_reg_write;
  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;
  logic [NREG-1:0]   r_pending;

  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_sel_reg;
  logic [DATA_W-1:0] w_sel_data;
  logic [NREG-1:0]   w_pending_nxt;
  logic              w_haz_rs1;
  logic              w_haz_rs2;

  // While reset is asserted, both ready outputs are held low, so no
  // transfer can be accepted at a reset edge.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (nrst) begin
      w_grant_b = b_valid && (!a_valid || r_prio);
      w_grant_a = a_valid && (!b_valid || !r_prio);
    end
  end

  assign a_ready    = w_grant_a;
  assign b_ready    = w_grant_b;
  assign w_xfer     = w_grant_a || w_grant_b;
  assign w_sel_reg  = w_grant_b ? b_reg  : a_reg;
  assign w_sel_data = w_grant_b ? b_data : a_data;

  // An issue to the same register as a completing load sets the bit again,
  // because it belongs to a newer load. Register 0 is never pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_grant_b && (b_reg != '0))
      w_pending_nxt[b_reg] = 1'b0;
    if (issue_valid && (issue_reg != '0))
      w_pending_nxt[issue_reg] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_prio       <= B_FIRST;
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_pending    <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_xfer) begin
        // Priority passes to the side that lost this round.
        r_prio       <= w_grant_a;
        // A write to x0 completes the handshake but produces no strobe.
        r_reg_write  <= (w_sel_reg != '0);
        r_write_reg  <= w_sel_reg;
        r_write_data <= w_sel_data;
      end else begin
        r_reg_write  <= 1'b0;
      end
    end
  end

  assign reg_write  = r_reg_write;
  assign write_reg  = r_write_reg;
  assign write_data = r_write_data;

  assign w_haz_rs1 = (rs1 != '0) && r_pending[rs1];
  assign w_haz_rs2 = (rs2 != '0) && r_pending[rs2];
  assign hazard    = nrst && (w_haz_rs1 || w_haz_rs2);

endmodule

// File: tb/tb_t07_regfile_wb_arbiter.sv
// Directed bench for t07_regfile_wb_arbiter with its default parameters
// (ADDR_W=5, DATA_W=32, B_FIRST=1).
module tb_t07_regfile_wb_arbiter;

  logic        clk;
  logic        nrst;
  logic        a_valid;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        b_ready;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  int n_checks = 0;
  int n_err    = 0;

  t07_regfile_wb_arbiter dut (
    .clk        (clk),
    .nrst       (nrst),
    .a_valid    (a_valid),
    .a_reg      (a_reg),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_reg      (b_reg),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .issue_valid(issue_valid),
    .issue_reg  (issue_reg),
    .rs1        (rs1),
    .rs2        (rs2),
    .hazard     (hazard),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge; registered outputs are stable here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #2;
  endtask

  initial begin
    nrst = 1'b0; a_valid = 1'b1; a_reg = 5'd1; a_data = 32'h1;
    b_valid = 1'b1; b_reg = 5'd2; b_data = 32'h2;
    issue_valid = 1'b0; issue_reg = '0; rs1 = 5'd9; rs2 = 5'd0;

    // Reset held with both requesters valid.
    step(); step();
    settle();
    check("rst_a_ready",   a_ready,    0);
    check("rst_b_ready",   b_ready,    0);
    check("rst_reg_write", reg_write,  0);
    check("rst_hazard",    hazard,     0);
    check("rst_write_reg", write_reg,  0);
    check("rst_write_data",write_data, 0);

    step();
    nrst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    settle();
    check("idle_reg_write", reg_write, 0);

    // Single A write.
    step();
    a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hDEAD_BEEF;
    settle();
    check("a_single_ready",  a_ready, 1);
    check("a_single_bready", b_ready, 0);
    step();
    a_valid = 1'b0;
    check("a_single_we",   reg_write,  1);
    check("a_single_reg",  write_reg,  5);
    check("a_single_data", write_data, 32'hDEAD_BEEF);
    step();
    check("idle_we_low",   reg_write, 0);
    check("idle_reg_hold", write_reg, 5);

    // Contention: B holds priority, so the grants alternate B,A,B,A.
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h0000_00A3;
    b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h0000_00B7;
    settle();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cont_b_ready_%0d", i), b_ready, (i % 2 == 0) ? 1 : 0);
      check($sformatf("cont_a_ready_%0d", i), a_ready, (i % 2 == 0) ? 0 : 1);
      step();
      if (i == 3) begin
        a_valid = 1'b0; b_valid = 1'b0;
      end
      check($sformatf("cont_we_%0d", i),   reg_write,  1);
      check($sformatf("cont_reg_%0d", i),  write_reg,  (i % 2 == 0) ? 7 : 3);
      check($sformatf("cont_data_%0d", i), write_data, (i % 2 == 0) ? 32'hB7 : 32'hA3);
      settle();
    end

    // Write to x0 completes the handshake but produces no strobe.
    a_valid = 1'b1; a_reg = 5'd0; a_data = 32'h1234;
    settle();
    check("x0_ready", a_ready, 1);
    step();
    a_valid = 1'b0;
    check("x0_no_we", reg_write, 0);

    // Scoreboard: issue a load to register 9.
    issue_valid = 1'b1; issue_reg = 5'd9; rs1 = 5'd9; rs2 = 5'd0;
    settle();
    check("sb_pre_issue", hazard, 0);
    step();
    issue_valid = 1'b0;
    settle();
    check("sb_haz_rs1", hazard, 1);
    rs1 = 5'd0; rs2 = 5'd9;
    settle();
    check("sb_haz_rs2", hazard, 1);
    rs1 = 5'd4; rs2 = 5'd0;
    settle();
    check("sb_no_haz_other", hazard, 0);
    rs1 = 5'd9;
    b_valid = 1'b1; b_reg = 5'd9; b_data = 32'h0000_0099;
    settle();
    check("sb_b_ready",        b_ready, 1);
    check("sb_haz_during_acc", hazard,  1);
    step();
    b_valid = 1'b0;
    settle();
    check("sb_haz_cleared", hazard,     0);
    check("sb_we",          reg_write,  1);
    check("sb_reg",         write_reg,  9);
    check("sb_data",        write_data, 32'h99);

    // An issue and a B completion to register 9 on the same edge leave it pending.
    issue_valid = 1'b1; issue_reg = 5'd9;
    step();
    issue_valid = 1'b0;
    settle();
    check("sb_reissue", hazard, 1);
    issue_valid = 1'b1; issue_reg = 5'd9;
    b_valid = 1'b1; b_reg = 5'd9; b_data = 32'h0000_0999;
    settle();
    check("sb_same_b_ready", b_ready, 1);
    step();
    issue_valid = 1'b0; b_valid = 1'b0;
    settle();
    check("sb_set_wins", hazard, 1);
    b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    settle();
    check("sb_final_clear", hazard, 0);

    // An issue to register 0 is ignored.
    issue_valid = 1'b1; issue_reg = 5'd0; rs1 = 5'd0;
    step();
    issue_valid = 1'b0;
    settle();
    check("sb_x0_ignored", hazard, 0);

    // Reset in the middle of operation: make register 12 pending, accept an
    // A write, then pull reset before the accepting edge.
    issue_valid = 1'b1; issue_reg = 5'd12; rs1 = 5'd12;
    step();
    issue_valid = 1'b0;
    settle();
    check("mid_pending12", hazard, 1);
    a_valid = 1'b1; a_reg = 5'd4; a_data = 32'h0000_0044;
    settle();
    check("mid_a_ready", a_ready, 1);
    nrst = 1'b0;
    settle();
    check("mid_a_ready_rst", a_ready, 0);
    check("mid_haz_rst",     hazard,  0);
    step();
    a_valid = 1'b0;
    check("mid_we_0", reg_write, 0);
    nrst = 1'b1;
    settle();
    check("mid_pending_cleared", hazard, 0);
    step();
    check("mid_we_1", reg_write, 0);
    // Priority returns to B after reset.
    a_valid = 1'b1; a_reg = 5'd1; b_valid = 1'b1; b_reg = 5'd2;
    settle();
    check("mid_prio_b", b_ready, 1);
    check("mid_prio_a", a_ready, 0);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    check("mid_post_reg", write_reg, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
